// File: rtl/bitwise_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bitwise_alu_pkg
// Description : Operation encoding and sizing helpers shared by the bitwise ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package bitwise_alu_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_ANOTB  = 3'd6,
        OP_PASS_A = 3'd7
    } op_e;

    // Bits needed to hold a count of 0..width ones.
    function automatic int popcnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bitwise_op.sv
`default_nettype none
// ============================================================================
// Module      : bitwise_op
// Description : Purely combinational bitwise function y = f(op, a, b).
// Revision    : 1.0 - initial release
// ============================================================================
module bitwise_op
    import bitwise_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op_e'(op))
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_XOR:    y = a ^ b;
            OP_NAND:   y = ~(a & b);
            OP_NOR:    y = ~(a | b);
            OP_XNOR:   y = ~(a ^ b);
            OP_ANOTB:  y = a & ~b;
            OP_PASS_A: y = a;
            default:   y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bitwise_alu.sv
`default_nettype none
// ============================================================================
// Module      : bitwise_alu
// Description : Registered bitwise logic unit with accumulator chaining,
//               valid/ready handshakes and popcount/zero result flags.
// Revision    : 1.0 - initial release
// ============================================================================
module bitwise_alu
    import bitwise_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = popcnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_popcnt
);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_result;
    logic [CNT_W-1:0] w_popcnt;
    logic             w_accept;

    function automatic logic [CNT_W-1:0] count_ones(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // The output slot frees up in the same cycle the consumer takes it.
    assign in_ready = ~out_valid | out_ready;
    assign w_accept = in_valid & in_ready;

    assign w_opa    = acc_mode ? (acc_clr ? '0 : r_acc) : a;
    assign w_popcnt = count_ones(w_result);

    bitwise_op #(
        .WIDTH (WIDTH)
    ) u_bitwise_op (
        .op (op),
        .a  (w_opa),
        .b  (b),
        .y  (w_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_zero   <= 1'b1;
            out_popcnt <= '0;
            r_acc      <= '0;
        end else if (w_accept) begin
            out_valid  <= 1'b1;
            out_data   <= w_result;
            out_zero   <= (w_result == '0);
            out_popcnt <= w_popcnt;
            // Chained results feed the next acc_mode transaction directly.
            if (acc_mode) begin
                r_acc <= w_result;
            end else if (acc_clr) begin
                r_acc <= '0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bitwise_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitwise_alu
// Description : Self-checking bench for bitwise_alu using a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitwise_alu;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, acc_mode, acc_clr, out_valid, out_ready, out_zero;
    logic [2:0] op;
    logic [7:0] a, b, out_data;
    logic [3:0] out_popcnt;

    logic        w1_in_ready, w1_out_valid, w1_out_zero;
    logic [0:0]  w1_out_data, w1_popcnt;
    logic        w33_in_ready, w33_out_valid, w33_out_zero;
    logic [32:0] w33_out_data;
    logic [5:0]  w33_popcnt;
    logic        wx_in_valid;
    logic [2:0]  wx_op;
    logic [0:0]  w1_ones;
    logic [32:0] w33_ones;

    int          checks = 0;
    int          failures = 0;
    int          pops = 0;
    string       phase = "reset";
    logic [7:0]  sb[$];

    always #5 clk = ~clk;

    bitwise_alu #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .acc_mode(acc_mode), .acc_clr(acc_clr), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero), .out_popcnt(out_popcnt)
    );

    bitwise_alu #(.WIDTH(1)) u_w1 (
        .clk(clk), .reset(reset), .in_valid(wx_in_valid), .in_ready(w1_in_ready), .op(wx_op),
        .acc_mode(1'b0), .acc_clr(1'b0), .a(w1_ones), .b(w1_ones), .out_valid(w1_out_valid),
        .out_ready(1'b1), .out_data(w1_out_data), .out_zero(w1_out_zero), .out_popcnt(w1_popcnt)
    );

    bitwise_alu #(.WIDTH(33)) u_w33 (
        .clk(clk), .reset(reset), .in_valid(wx_in_valid), .in_ready(w33_in_ready), .op(wx_op),
        .acc_mode(1'b0), .acc_clr(1'b0), .a(w33_ones), .b(w33_ones), .out_valid(w33_out_valid),
        .out_ready(1'b1), .out_data(w33_out_data), .out_zero(w33_out_zero), .out_popcnt(w33_popcnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s observed=0x%0h expected=0x%0h", phase, tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ones(input logic [7:0] v);
        logic [3:0] n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
        return n;
    endfunction

    function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return ~(x & y);
            3'd4:    return ~(x | y);
            3'd5:    return ~(x ^ y);
            3'd6:    return x & ~y;
            default: return x;
        endcase
    endfunction

    task automatic pop_check();
        logic [7:0] e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s/unexpected_output observed=0x%0h expected=none", phase, out_data);
        end else begin
            e = sb.pop_front();
            chk("data", {56'd0, out_data}, {56'd0, e});
            chk("zero", {63'd0, out_zero}, {63'd0, (e == 8'h00)});
            chk("popcnt", {60'd0, out_popcnt}, {60'd0, ones(e)});
            pops++;
        end
    endtask

    // Score the handshakes happening at the coming edge, then advance one cycle.
    task automatic tick(input logic [7:0] exp);
        #1;
        if (out_valid && out_ready) pop_check();
        if (in_valid && in_ready) sb.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] o, input logic am, input logic ac,
                        input logic [7:0] aa, input logic [7:0] bb, input logic [7:0] exp);
        op = o; acc_mode = am; acc_clr = ac; a = aa; b = bb; in_valid = 1'b1;
        tick(exp);
        in_valid = 1'b0; acc_mode = 1'b0; acc_clr = 1'b0;
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(8'h00);
    endtask

    initial begin
        logic [7:0] exp_ops [8];
        int         pops0;
        exp_ops = '{8'h48, 8'hDE, 8'h96, 8'hB7, 8'h21, 8'h69, 8'h82, 8'hCA};
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 3'd0;
        acc_mode = 1'b0; acc_clr = 1'b0; a = 8'h00; b = 8'h00;
        wx_in_valid = 1'b0; wx_op = 3'd0; w1_ones = '1; w33_ones = '1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {56'd0, out_data}, 64'd0);
        chk("rst_out_zero", {63'd0, out_zero}, 64'd1);
        chk("rst_out_popcnt", {60'd0, out_popcnt}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        phase = "ops";
        for (int i = 0; i < 8; i++) send(3'(i), 1'b0, 1'b0, 8'hCA, 8'h5C, exp_ops[i]);
        drain(1);

        phase = "acc";
        send(3'd1, 1'b1, 1'b1, 8'hAA, 8'h0F, 8'h0F);
        send(3'd1, 1'b1, 1'b0, 8'h00, 8'hF0, 8'hFF);
        send(3'd2, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h00);
        send(3'd1, 1'b1, 1'b0, 8'h00, 8'h33, 8'h33);
        send(3'd7, 1'b0, 1'b1, 8'h5A, 8'h00, 8'h5A);
        send(3'd1, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h00);
        drain(1);

        phase = "backpressure";
        send(3'd0, 1'b0, 1'b0, 8'hFF, 8'h0F, 8'h0F);
        out_ready = 1'b0;
        op = 3'd2; a = 8'hF0; b = 8'h0F; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(8'hFF);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_hold", {56'd0, out_data}, 64'h0F);
        end
        out_ready = 1'b1;
        tick(8'hFF);
        drain(2);

        phase = "stream";
        pops0 = pops;
        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
            acc_mode = 1'b0; acc_clr = 1'b0; in_valid = 1'b1;
            tick(model(op, a, b));
            chk("stream_valid", {63'd0, out_valid}, 64'd1);
        end
        drain(1);
        chk("stream_count", 64'(pops - pops0), 64'd16);

        phase = "reset_mid";
        send(3'd1, 1'b1, 1'b1, 8'h00, 8'h3C, 8'h3C);
        out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_out_valid", {63'd0, out_valid}, 64'd0);
        chk("async_out_data", {56'd0, out_data}, 64'd0);
        chk("async_out_zero", {63'd0, out_zero}, 64'd1);
        chk("async_out_popcnt", {60'd0, out_popcnt}, 64'd0);
        chk("async_in_ready", {63'd0, in_ready}, 64'd1);
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(8'h00);
            chk("no_stale", {63'd0, out_valid}, 64'd0);
        end
        send(3'd2, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        drain(1);

        phase = "widths";
        wx_op = 3'd3; wx_in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("w1_nand_data", {63'd0, w1_out_data}, 64'd0);
        chk("w1_nand_zero", {63'd0, w1_out_zero}, 64'd1);
        chk("w33_nand_data", {31'd0, w33_out_data}, 64'd0);
        chk("w33_nand_zero", {63'd0, w33_out_zero}, 64'd1);
        wx_op = 3'd7;
        @(posedge clk);
        #1;
        chk("w1_pass_popcnt", {63'd0, w1_popcnt}, 64'd1);
        chk("w33_pass_popcnt", {58'd0, w33_popcnt}, 64'd33);
        chk("w33_pass_zero", {63'd0, w33_out_zero}, 64'd0);
        wx_in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bitwise_alu.md
# bitwise_alu

Parametrised, registered bitwise logic unit: the successor to the two-input gate block.
- One selectable logic operation on two WIDTH-bit operands per transaction, with an optional accumulator mode that chains results.
- Valid/ready handshakes on both sides; result registered with popcount and zero flags.
- Sits between operand producers and downstream datapath consumers.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥1)
- CNT_W, $clog2(WIDTH+1), derived; popcount width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  operand transaction offered
- in_ready  out  1  unit can accept this cycle
- op  in  3  operation select (encoding below)
- acc_mode  in  1  operand A taken from accumulator instead of a
- acc_clr  in  1  clear accumulator (effective only on accepted transaction)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result held in output register
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  result
- out_zero  out  1  out_data == 0
- out_popcnt  out  CNT_W  number of ones in out_data

## Operation
- Op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANOTB (A & ~B), 7 PASS_A. All bitwise over WIDTH bits.
- Accept = in_valid & in_ready. op, acc_mode, acc_clr, a and b are sampled only on accept.
- Effective operand A:
  - acc_mode=0: a.
  - acc_mode=1: accumulator; zero if acc_clr=1 in the same accepted cycle.
- On accept:
  - out_data <= f(op, A, b).
  - out_zero and out_popcnt are computed from that same result and registered with it.
  - out_valid <= 1.
- Accumulator:
  - Loaded with the result on every accepted transaction with acc_mode=1.
  - acc_clr with acc_mode=0 clears it to 0; the result is computed from a as normal.
  - Unchanged on all other cycles.
- Output register holds its value while out_valid=1 and out_ready=0.
- out_valid clears on out_ready with no new accept in the same cycle.
- Popcount range is 0..WIDTH; no overflow is possible at width CNT_W.

## Timing
- Latency: 1 cycle from accept to out_valid=1 with the result.
- Throughput: 1 transaction/cycle while out_ready=1.
- in_ready = ~out_valid | out_ready, combinational. This is the only combinational in→out path.
- Simultaneous output handshake and new accept: the register is replaced by the new result and out_valid stays 1, with no bubble.
- Back-to-back acc_mode transactions: the second uses the first's result, with no hazard stall.
- Reset values: out_valid=0, out_data=0, out_zero=1, out_popcnt=0, accumulator=0; in_ready=1 after reset.
- Reset asserted mid-transfer: a pending result is discarded and nothing is emitted after release until a new accept.
- Downstream stall: the output is stable and in_ready=0 until out_ready.

## Structure
- Package bitwise_alu_pkg:
  - op_e enum (3 bits, values above).
  - Popcount width function.
- Sub-module bitwise_op: purely combinational f(op, A, B) over WIDTH bits, reusable elsewhere.
- The top level holds the handshake, the accumulator, the output register and flag generation.

## Test plan
- Each op, WIDTH=8, a=8'hCA, b=8'h5C, out_ready=1 → 0x48, 0xDE, 0x96, 0xB7, 0x21, 0x69, 0x82, 0xCA. out_popcnt and out_zero are checked on every result.
- Accumulator: acc_clr+acc_mode with OR b=0x0F, then OR b=0xF0, then XOR b=0xFF → 0x0F, 0xFF, 0x00. The last result has out_zero=1 and popcnt=0.
- Backpressure: out_ready held 0 for 3 cycles after one accept. Expect in_ready=0, out_data stable and the second operand not consumed. On release, both results are delivered in order.
- Full streaming: in_valid=1 and out_ready=1 for 16 cycles with random ops. Expect 16 results, 1-cycle latency and no bubbles.
- Reset pulse while out_valid=1 and stalled → all outputs at reset values asynchronously; no stale result after release.
- WIDTH=1 and WIDTH=33 builds: NAND of all-ones operands gives zero with out_zero=1. PASS_A of all-ones gives popcnt=WIDTH.
